// File: rtl/keypad_top_if.sv
// Board pin group for the keypad-entry board: keypad matrix rows and columns,
// plus the 4-digit 7-segment display and the reset indicator.
interface keypad_top_if;
    logic [3:0] fil;
    logic       rst_1;
    logic [3:0] col;
    logic [6:0] seg;
    logic       seg_dot;
    logic [3:0] cats;

    // master: the board/keypad side; slave: the keypad_top controller
    modport master (output fil, input rst_1, col, seg, seg_dot, cats);
    modport slave  (input fil, output rst_1, col, seg, seg_dot, cats);
endinterface

// File: rtl/keypad_top.sv
// Keypad-entry board top: scans a 4x4 matrix keypad, debounces presses and releases,
// shifts accepted decimal digits into a 4-digit BCD number, and drives a multiplexed
// 4-digit 7-segment display showing that number.
module keypad_top #(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned DEBOUNCE    = 5,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_in,
    keypad_top_if.slave       pins_io
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DebW  = $clog2(DEBOUNCE + 1);
    localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE - 1);
    localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_DIV - 1);

    // Non-digit key codes; digits use their own value 0..9
    localparam logic [3:0] KeyStar = 4'hE;
    localparam logic [3:0] KeyHash = 4'hF;

    typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

    logic [1:0]       rst_q;
    logic             srst;
    logic [3:0]       fil_s1_q, fil_s2_q;
    state_e           state_q, state_d;
    logic [3:0]       col_q, col_d;
    logic [ScanW-1:0] dwell_q, dwell_d;
    logic [DebW-1:0]  deb_q, deb_d;
    logic [3:0]       fil_ref_q, fil_ref_d;
    logic             key_stb_q, key_stb_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [3:0]       key_val;
    logic [1:0]       row_idx, col_idx;
    logic [15:0]      num_q, num_d;
    logic [RefW-1:0]  ref_q, ref_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       digit;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       cats_q, cats_d;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        unique case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // Reset synchronizer: internal reset releases on the 2nd edge after rst_in rises
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) rst_q <= 2'b11;
        else         rst_q <= {rst_q[0], 1'b0};
    end
    assign srst = rst_q[1];

    // Two-stage synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            fil_s1_q <= '0;
            fil_s2_q <= '0;
        end else begin
            fil_s1_q <= pins_io.fil;
            fil_s2_q <= fil_s1_q;
        end
    end

    // Key decode: lowest asserted row wins, column taken from the held drive
    always_comb begin
        row_idx = 2'd3;
        if      (fil_s2_q[0]) row_idx = 2'd0;
        else if (fil_s2_q[1]) row_idx = 2'd1;
        else if (fil_s2_q[2]) row_idx = 2'd2;
        col_idx = 2'd3;
        if      (col_q[0]) col_idx = 2'd0;
        else if (col_q[1]) col_idx = 2'd1;
        else if (col_q[2]) col_idx = 2'd2;
        key_val = KeyHash;
        case ({row_idx, col_idx})
            4'h0: key_val = 4'd1;
            4'h1: key_val = 4'd2;
            4'h2: key_val = 4'd3;
            4'h3: key_val = 4'hA;
            4'h4: key_val = 4'd4;
            4'h5: key_val = 4'd5;
            4'h6: key_val = 4'd6;
            4'h7: key_val = 4'hB;
            4'h8: key_val = 4'd7;
            4'h9: key_val = 4'd8;
            4'hA: key_val = 4'd9;
            4'hB: key_val = 4'hC;
            4'hC: key_val = KeyStar;
            4'hD: key_val = 4'd0;
            4'hE: key_val = KeyHash;
            default: key_val = 4'hD;
        endcase
    end

    // Scan/debounce FSM next-state; the entry cycle counts as the first stable cycle
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        dwell_d    = dwell_q;
        deb_d      = deb_q;
        fil_ref_d  = fil_ref_q;
        key_stb_d  = 1'b0;
        key_code_d = key_code_q;
        unique case (state_q)
            StScan: begin
                if (fil_s2_q != 4'b0000) begin
                    state_d   = StDebounce;
                    fil_ref_d = fil_s2_q;
                    deb_d     = DebW'(1);
                end else if (dwell_q == ScanLast) begin
                    dwell_d = '0;
                    col_d   = {col_q[2:0], col_q[3]};
                end else begin
                    dwell_d = dwell_q + ScanW'(1);
                end
            end
            StDebounce: begin
                if (fil_s2_q == 4'b0000) begin
                    state_d = StScan;
                    dwell_d = '0;
                end else if (fil_s2_q != fil_ref_q) begin
                    fil_ref_d = fil_s2_q;
                    deb_d     = DebW'(1);
                end else if (deb_q >= DebLast) begin
                    state_d    = StHeld;
                    key_stb_d  = 1'b1;
                    key_code_d = key_val;
                end else begin
                    deb_d = deb_q + DebW'(1);
                end
            end
            StHeld: begin
                if (fil_s2_q == 4'b0000) begin
                    state_d = StRelease;
                    deb_d   = DebW'(1);
                end
            end
            StRelease: begin
                if (fil_s2_q != 4'b0000) begin
                    state_d = StHeld;
                end else if (deb_q >= DebLast) begin
                    state_d = StScan;
                    dwell_d = '0;
                end else begin
                    deb_d = deb_q + DebW'(1);
                end
            end
            default: state_d = StScan;
        endcase
    end

    // Number register: digits shift in from the right, '*' clears, others ignored
    always_comb begin
        num_d = num_q;
        if (key_stb_q) begin
            if (key_code_q <= 4'd9)         num_d = {num_q[11:0], key_code_q};
            else if (key_code_q == KeyStar) num_d = '0;
        end
    end

    // Display mux: advance the selected digit every REFRESH_DIV cycles
    always_comb begin
        ref_d = ref_q + RefW'(1);
        sel_d = sel_q;
        if (ref_q == RefLast) begin
            ref_d = '0;
            sel_d = sel_q + 2'd1;
        end
        unique case (sel_d)
            2'd0:    digit = num_q[3:0];
            2'd1:    digit = num_q[7:4];
            2'd2:    digit = num_q[11:8];
            default: digit = num_q[15:12];
        endcase
        seg_d  = glyph(digit);
        cats_d = ~(4'b0001 << sel_d);
    end

    // All state: async clear on rst_in, held cleared while the internal reset is active
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in || srst) begin
            state_q    <= StScan;
            col_q      <= 4'b0001;
            dwell_q    <= '0;
            deb_q      <= '0;
            fil_ref_q  <= '0;
            key_stb_q  <= 1'b0;
            key_code_q <= '0;
            num_q      <= '0;
            ref_q      <= '0;
            sel_q      <= '0;
            seg_q      <= 7'b1000000;
            cats_q     <= 4'b1110;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            dwell_q    <= dwell_d;
            deb_q      <= deb_d;
            fil_ref_q  <= fil_ref_d;
            key_stb_q  <= key_stb_d;
            key_code_q <= key_code_d;
            num_q      <= num_d;
            ref_q      <= ref_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            cats_q     <= cats_d;
        end
    end

    assign pins_io.rst_1   = rst_q[1];
    assign pins_io.col     = col_q;
    assign pins_io.seg     = seg_q;
    assign pins_io.seg_dot = 1'b1;
    assign pins_io.cats    = cats_q;

endmodule

// File: tb/tb_keypad_top.sv
// Directed bench for keypad_top with a small keypad model: a single key closes the row
// line only while its column is driven.
module tb_keypad_top;

    logic clk = 1'b0;
    logic rst_in;
    logic key_on;
    logic [1:0] key_row, key_col;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    keypad_top_if pins ();

    keypad_top #(
        .SCAN_DIV   (4),
        .DEBOUNCE   (3),
        .REFRESH_DIV(8)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .pins_io(pins)
    );

    always #5 clk = ~clk;

    assign pins.fil = (key_on && (pins.col == (4'b0001 << key_col))) ?
                      (4'b0001 << key_row) : 4'b0000;

    function automatic logic [6:0] exp_glyph(input logic [3:0] d);
        case (d)
            4'd0:    exp_glyph = 7'b1000000;
            4'd1:    exp_glyph = 7'b1111001;
            4'd2:    exp_glyph = 7'b0100100;
            4'd3:    exp_glyph = 7'b0110000;
            4'd4:    exp_glyph = 7'b0011001;
            4'd5:    exp_glyph = 7'b0010010;
            4'd6:    exp_glyph = 7'b0000010;
            4'd7:    exp_glyph = 7'b1111000;
            4'd8:    exp_glyph = 7'b0000000;
            4'd9:    exp_glyph = 7'b0010000;
            default: exp_glyph = 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_row = r;
        key_col = c;
        key_on  = 1'b1;
        cycles(40);
        key_on  = 1'b0;
        cycles(15);
    endtask

    task automatic wait_col(input logic [3:0] want);
        int n;
        n = 0;
        while (pins.col !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_col", {28'd0, pins.col}, {28'd0, want});
    endtask

    // Walk the display through all four digit positions and check each glyph
    task automatic check_display(input string tag, input logic [15:0] exp);
        logic [3:0] want;
        int n;
        for (int i = 0; i < 4; i++) begin
            want = ~(4'b0001 << i);
            n = 0;
            while (pins.cats !== want && n < 40) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("%s_cats%0d", tag, i), {28'd0, pins.cats}, {28'd0, want});
            check($sformatf("%s_seg%0d", tag, i), {25'd0, pins.seg},
                  {25'd0, exp_glyph(exp[i*4 +: 4])});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in = 1'b0;
        cycles(5);
        rst_in = 1'b1;
        cycles(4);
    endtask

    initial begin
        key_on  = 1'b0;
        key_row = 2'd0;
        key_col = 2'd0;
        rst_in  = 1'b1;
        #2 rst_in = 1'b0;
        cycles(5);
        check("rst_col",  {28'd0, pins.col},  32'b0001);
        check("rst_cats", {28'd0, pins.cats}, 32'b1110);
        check("rst_seg",  {25'd0, pins.seg},  32'b1000000);
        check("rst_dot",  {31'd0, pins.seg_dot}, 32'd1);
        check("rst_ind",  {31'd0, pins.rst_1},   32'd1);

        // Release: indicator drops on the 2nd edge, then col dwells 4 cycles per column
        rst_in = 1'b1;
        cycles(1);
        check("rst1_edge1", {31'd0, pins.rst_1}, 32'd1);
        cycles(1);
        check("rst1_edge2", {31'd0, pins.rst_1}, 32'd0);
        cycles(3);
        check("col_edge5",  {28'd0, pins.col}, 32'b0001);
        cycles(1);
        check("col_edge6",  {28'd0, pins.col}, 32'b0010);
        cycles(4);
        check("col_edge10", {28'd0, pins.col}, 32'b0100);

        // '3' then '7'
        press(2'd0, 2'd2);
        check_display("k3", 16'h0003);
        press(2'd2, 2'd0);
        check_display("k37", 16'h0037);

        // Bouncy press of '3' then stable: one digit
        key_row = 2'd0;
        key_col = 2'd2;
        wait_col(4'b0100);
        for (int i = 0; i < 10; i++) begin
            key_on = ~key_on;
            cycles(1);
        end
        key_on = 1'b1;
        cycles(40);
        key_on = 1'b0;
        cycles(15);
        check_display("bounce", 16'h0373);

        // Two-cycle glitch: ignored
        wait_col(4'b0100);
        key_on = 1'b1;
        cycles(2);
        key_on = 1'b0;
        cycles(30);
        check_display("glitch", 16'h0373);

        // Overflow, clear, and non-digit keys
        do_reset();
        check_display("cleared", 16'h0000);
        press(2'd0, 2'd0);
        press(2'd0, 2'd1);
        press(2'd0, 2'd2);
        press(2'd1, 2'd0);
        press(2'd1, 2'd1);
        check_display("ovf", 16'h2345);
        press(2'd3, 2'd0);
        check_display("star", 16'h0000);
        press(2'd3, 2'd2);
        press(2'd0, 2'd3);
        check_display("hashA0", 16'h0000);
        press(2'd2, 2'd2);
        press(2'd3, 2'd2);
        press(2'd0, 2'd3);
        check_display("hashA9", 16'h0009);

        // Reset while '5' is held: async clear, then re-detected after release of reset
        key_row = 2'd1;
        key_col = 2'd1;
        key_on  = 1'b1;
        cycles(40);
        #2 rst_in = 1'b0;
        #1;
        check("mid_col",  {28'd0, pins.col},  32'b0001);
        check("mid_cats", {28'd0, pins.cats}, 32'b1110);
        check("mid_seg",  {25'd0, pins.seg},  32'b1000000);
        check("mid_dot",  {31'd0, pins.seg_dot}, 32'd1);
        check("mid_ind",  {31'd0, pins.rst_1},   32'd1);
        cycles(5);
        rst_in = 1'b1;
        cycles(40);
        key_on = 1'b0;
        cycles(15);
        check_display("rehold", 16'h0005);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
